// File: rtl/mem_fifo_pkg.sv
// Shared defaults, grant type and pointer-wrap helper for the mem-backed FIFO controller.
// Latency: none (types and functions only). Backpressure: not applicable.
package mem_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 100;

    typedef struct packed {
        logic rd;
        logic wr;
    } grant_t;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mem_fifo_arb.sv
// Read/write arbiter for the shared memory port pair; round-robin on conflict via prio_wr.
// Latency: grants are combinational from the wants; prio_wr updates on the conflict edge.
// Backpressure: the losing requester is simply not granted this cycle.
module mem_fifo_arb
    import mem_fifo_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   rd_want,
    input  logic   wr_want,
    output logic   prio_wr,
    output grant_t grant
);

    logic conflict;

    assign conflict = rd_want && wr_want;
    assign grant.wr = wr_want && (!rd_want || prio_wr);
    assign grant.rd = rd_want && (!wr_want || !prio_wr);

    // Priority only moves when both sides actually competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_wr <= 1'b0;
        end else if (conflict) begin
            prio_wr <= !prio_wr;
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller around an external sync memory; optional MEM_FIFO_LEVEL_EN adds a level output.
// Latency: push to first pop 2 cycles; memory read data appears one cycle after mem_rd_en.
// Backpressure: s_ready drops when full or when a read wins arbitration; m_ready low holds m_data.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDRSIZE   = $clog2(DEPTH),
    parameter int CNTW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  mem_rd_en,
    output logic [ADDRSIZE-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDRSIZE-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
`ifdef MEM_FIFO_LEVEL_EN
    ,
    output logic [CNTW-1:0]       level
`endif
);

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [ADDRSIZE-1:0] wr_ptr;
    logic [ADDRSIZE-1:0] rd_ptr;
    logic [CNTW-1:0]     mem_cnt;
    logic                not_empty;
    logic                not_full;
    logic                rd_want;
    logic                wr_want;
    logic                prio_wr;
    grant_t              grant;

    function automatic logic [ADDRSIZE-1:0] ptr_inc(input logic [ADDRSIZE-1:0] p);
        return ADDRSIZE'(wrap_inc(int'(p), DEPTH));
    endfunction

    assign not_empty = (mem_cnt != '0);
    assign not_full  = (mem_cnt != FULL_CNT);

    // mem_cnt is zero in reset, so only the write side needs explicit gating.
    assign rd_want = not_empty && (!m_valid || m_ready);
    assign wr_want = rst_n && s_valid && not_full;

    mem_fifo_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_want (rd_want),
        .wr_want (wr_want),
        .prio_wr (prio_wr),
        .grant   (grant)
    );

    assign s_ready     = rst_n && not_full && (!rd_want || prio_wr);
    assign mem_wr_en   = grant.wr;
    assign mem_rd_en   = grant.rd;
    assign mem_wr_addr = wr_ptr;
    assign mem_rd_addr = rd_ptr;
    assign mem_wr_data = s_data;
    assign m_data      = mem_rd_data;

`ifdef MEM_FIFO_LEVEL_EN
    assign level = mem_cnt + CNTW'(m_valid);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            m_valid <= 1'b0;
        end else begin
            if (grant.wr) begin
                wr_ptr  <= ptr_inc(wr_ptr);
                mem_cnt <= mem_cnt + CNTW'(1);
            end else if (grant.rd) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                mem_cnt <= mem_cnt - CNTW'(1);
            end
            // The word in flight leaves the count on the read; m_valid tracks it from here.
            if (grant.rd) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    a_excl_strobe: assert property (@(posedge clk) disable iff (!rst_n) !(mem_rd_en && mem_wr_en));
    a_cnt_range:   assert property (@(posedge clk) disable iff (!rst_n) mem_cnt <= FULL_CNT);

endmodule
